// File: rtl/ascon_perm_engine_pkg.sv
// Shared types and helpers for the ASCON permutation engine and its round datapath.
package ascon_perm_engine_pkg;

  typedef enum logic [1:0] {
    OP_INIT  = 2'd0,
    OP_AD    = 2'd1,
    OP_PT    = 2'd2,
    OP_FINAL = 2'd3
  } ascon_op_t;

  localparam logic [63:0] IV_128  = 64'h80400c0600000000;
  localparam logic [63:0] IV_128A = 64'h80800c0800000000;

  // Round constant for absolute round index r (0..11) of the 12-round schedule.
  function automatic logic [7:0] rc(input logic [3:0] r);
    return {4'hF - r, r};
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_perm_engine_if.sv
// Request/response bundle between the mode controller (master) and the permutation engine (slave).
interface ascon_perm_engine_if
  import ascon_perm_engine_pkg::*;
#(
  parameter int RATE = 64
);
  logic            start_i;
  ascon_op_t       op_i;
  logic            last_i;
  logic [319:0]    state_i;
  logic [RATE-1:0] data_i;
  logic [127:0]    key_i;
  logic            ready_o;
  logic            done_o;
  logic [319:0]    state_o;
  logic [RATE-1:0] cipher_o;
  logic [127:0]    tag_o;

  modport master (
    output start_i, op_i, last_i, state_i, data_i, key_i,
    input  ready_o, done_o, state_o, cipher_o, tag_o
  );

  modport slave (
    input  start_i, op_i, last_i, state_i, data_i, key_i,
    output ready_o, done_o, state_o, cipher_o, tag_o
  );
endinterface

// File: rtl/ascon_perm_engine_round.sv
// One combinational ASCON round: constant addition, bitsliced S-box layer, linear diffusion.
module ascon_round
  import ascon_perm_engine_pkg::*;
(
  input  logic [319:0] state,
  input  logic [3:0]   round_idx,
  output logic [319:0] next_state
);

  // NOTE: combinational logic uses blocking '=' so each step sees the previous one; every
  // variable is fully assigned on every pass, so no latch is inferred.
  always_comb begin
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    x0 = state[319:256];
    x1 = state[255:192];
    x2 = state[191:128] ^ {56'h0, rc(round_idx)};
    x3 = state[127:64];
    x4 = state[63:0];

    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;

    next_state = {x0 ^ ror64(x0, 19) ^ ror64(x0, 28),
                  x1 ^ ror64(x1, 61) ^ ror64(x1, 39),
                  x2 ^ ror64(x2, 1)  ^ ror64(x2, 6),
                  x3 ^ ror64(x3, 10) ^ ror64(x3, 17),
                  x4 ^ ror64(x4, 7)  ^ ror64(x4, 41)};
  end

endmodule

// File: rtl/ascon_perm_engine.sv
// Self-sequencing ASCON permutation engine: runs one INIT/AD/PT/FINAL phase per accepted start,
// applying UNROLL rounds per clock plus the phase's pre- and post-permutation XORs.
module ascon_perm_engine
  import ascon_perm_engine_pkg::*;
#(
  parameter int RATE   = 64,
  parameter int UNROLL = 1,
  parameter int PA     = 12,
  parameter int PB     = 6
)(
  input logic                clock_i,
  input logic                resetb_i,
  ascon_perm_engine_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]             fsm_q;
  logic [3:0]             round_q;
  ascon_op_t              op_q;
  logic                   last_q;
  logic [319:0]           state_q;
  logic [RATE-1:0]        cipher_q;
  logic [127:0]           tag_q;

  logic [UNROLL:0][319:0] chain;
  logic [319:0]           load_state;
  logic [319:0]           post_mask;
  logic [319:0]           final_state;
  logic [3:0]             n_rounds;
  logic                   last_step;

  assign chain[0] = state_q;
  for (genvar g = 0; g < UNROLL; g++) begin : g_round
    ascon_round u_round (
      .state      (chain[g]),
      .round_idx  (round_q + 4'(g)),
      .next_state (chain[g+1])
    );
  end

  // State as it must look right after the accept edge, before any round runs.
  always_comb begin
    load_state = state_q;
    case (bus.op_i)
      OP_INIT:      load_state = bus.state_i;
      OP_AD, OP_PT: load_state = state_q ^ {bus.data_i, {(320-RATE){1'b0}}};
      OP_FINAL:     load_state = state_q ^ {{RATE{1'b0}}, bus.key_i, {(192-RATE){1'b0}}};
      default:      load_state = state_q;
    endcase
  end

  always_comb begin
    n_rounds = (bus.op_i == OP_AD || bus.op_i == OP_PT) ? 4'(PB) : 4'(PA);
    if (bus.op_i == OP_PT && bus.last_i) n_rounds = 4'd0;
  end

  // The key is not latched: the controller holds it stable for the whole message.
  always_comb begin
    post_mask = '0;
    case (op_q)
      OP_INIT, OP_FINAL: post_mask = {192'h0, bus.key_i};
      OP_AD:             post_mask = {319'h0, last_q};
      default:           post_mask = '0;
    endcase
  end

  assign last_step   = ({1'b0, round_q} + 5'(UNROLL)) == 5'd12;
  assign final_state = chain[UNROLL] ^ post_mask;

  // NOTE: sequential state uses non-blocking '<=' so every register updates from pre-edge values;
  // the wide state register is reset like any other flop so state_o is defined from reset.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q    <= S_IDLE;
      round_q  <= 4'd0;
      op_q     <= OP_INIT;
      last_q   <= 1'b0;
      state_q  <= '0;
      cipher_q <= '0;
      tag_q    <= '0;
    end else begin
      case (fsm_q)
        S_IDLE: if (bus.start_i) begin
          op_q    <= bus.op_i;
          last_q  <= bus.last_i;
          round_q <= 4'd12 - n_rounds;
          state_q <= load_state;
          if (bus.op_i == OP_PT) cipher_q <= load_state[319 -: RATE];
          fsm_q   <= (n_rounds == 4'd0) ? S_DONE : S_RUN;
        end
        S_RUN: begin
          round_q <= round_q + 4'(UNROLL);
          if (last_step) begin
            state_q <= final_state;
            if (op_q == OP_FINAL) tag_q <= final_state[127:0];
            fsm_q   <= S_DONE;
          end else begin
            state_q <= chain[UNROLL];
          end
        end
        S_DONE:  fsm_q <= S_IDLE;
        default: fsm_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ready_o  = (fsm_q == S_IDLE);
  assign bus.done_o   = (fsm_q == S_DONE);
  assign bus.state_o  = state_q;
  assign bus.cipher_o = cipher_q;
  assign bus.tag_o    = tag_q;

endmodule

// File: tb/tb_ascon_perm_engine.sv
// Bench: four Ascon-128 engines (UNROLL 1/2/3/6) driven in lockstep plus one Ascon-128a engine,
// each compared every cycle against a table-driven reference permutation model.
module tb_ascon_perm_engine;
  import ascon_perm_engine_pkg::*;

  localparam int NI = 5;
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Per-group drive: group 0 = the four Ascon-128 engines, group 1 = the Ascon-128a engine.
  logic         d_start [2];
  logic [1:0]   d_op    [2];
  logic         d_last  [2];
  logic [319:0] d_state [2];
  logic [127:0] d_data  [2];
  logic [127:0] d_key   [2];

  logic [NI-1:0]        o_ready, o_done;
  logic [NI-1:0][319:0] o_state;
  logic [NI-1:0][127:0] o_cipher, o_tag;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 4; g++) begin : g64
    localparam int UN = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 6;
    ascon_perm_engine_if #(.RATE(64)) bus ();
    assign bus.start_i = d_start[0];
    assign bus.op_i    = ascon_op_t'(d_op[0]);
    assign bus.last_i  = d_last[0];
    assign bus.state_i = d_state[0];
    assign bus.data_i  = d_data[0][63:0];
    assign bus.key_i   = d_key[0];
    ascon_perm_engine #(.RATE(64), .UNROLL(UN), .PA(12), .PB(6)) dut (
      .clock_i  (clk),
      .resetb_i (rst_n),
      .bus      (bus)
    );
    assign o_ready[g]  = bus.ready_o;
    assign o_done[g]   = bus.done_o;
    assign o_state[g]  = bus.state_o;
    assign o_cipher[g] = {64'h0, bus.cipher_o};
    assign o_tag[g]    = bus.tag_o;
  end

  ascon_perm_engine_if #(.RATE(128)) bus_a ();
  assign bus_a.start_i = d_start[1];
  assign bus_a.op_i    = ascon_op_t'(d_op[1]);
  assign bus_a.last_i  = d_last[1];
  assign bus_a.state_i = d_state[1];
  assign bus_a.data_i  = d_data[1];
  assign bus_a.key_i   = d_key[1];
  ascon_perm_engine #(.RATE(128), .UNROLL(1), .PA(12), .PB(8)) dut_a (
    .clock_i  (clk),
    .resetb_i (rst_n),
    .bus      (bus_a)
  );
  assign o_ready[4]  = bus_a.ready_o;
  assign o_done[4]   = bus_a.done_o;
  assign o_state[4]  = bus_a.state_o;
  assign o_cipher[4] = bus_a.cipher_o;
  assign o_tag[4]    = bus_a.tag_o;

  function automatic int grp_of(input int i);
    return (i == 4) ? 1 : 0;
  endfunction
  function automatic int rate_of(input int i);
    return (i == 4) ? 128 : 64;
  endfunction
  function automatic int pb_of(input int i);
    return (i == 4) ? 8 : 6;
  endfunction
  function automatic int unroll_of(input int i);
    case (i)
      1:       return 2;
      2:       return 3;
      3:       return 6;
      default: return 1;
    endcase
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Reference permutation: last nr rounds of 12, S-box applied column by column from the table.
  function automatic logic [319:0] perm(input logic [319:0] s, input int nr);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  col, o;
    for (int k = 0; k < 5; k++) x[k] = s[319-64*k -: 64];
    for (int r = 12 - nr; r < 12; r++) begin
      x[2] = x[2] ^ {56'h0, 4'(15 - r), 4'(r)};
      for (int b = 0; b < 64; b++) begin
        col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        o   = SBOX[col];
        for (int k = 0; k < 5; k++) y[k][b] = o[4-k];
      end
      x[0] = y[0] ^ ror(y[0], 19) ^ ror(y[0], 28);
      x[1] = y[1] ^ ror(y[1], 61) ^ ror(y[1], 39);
      x[2] = y[2] ^ ror(y[2], 1)  ^ ror(y[2], 6);
      x[3] = y[3] ^ ror(y[3], 10) ^ ror(y[3], 17);
      x[4] = y[4] ^ ror(y[4], 7)  ^ ror(y[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  // Model: expected end-of-phase outputs plus age = edges since accept (0 = idle).
  logic [319:0] m_state  [NI];
  logic [127:0] m_cipher [NI];
  logic [127:0] m_tag    [NI];
  int           m_age    [NI];
  int           m_lat    [NI];

  always @(posedge clk or negedge rst_n) begin
    logic [319:0] s;
    int           n, g;
    logic [1:0]   op;
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        m_state[i] = '0; m_cipher[i] = '0; m_tag[i] = '0; m_age[i] = 0; m_lat[i] = 1;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        g = grp_of(i);
        if (m_age[i] == 0) begin
          if (d_start[g]) begin
            op = d_op[g];
            n  = (op == 2'd1 || op == 2'd2) ? pb_of(i) : 12;
            if (op == 2'd2 && d_last[g]) n = 0;
            s = m_state[i];
            case (op)
              2'd0:       s = d_state[g];
              2'd1, 2'd2: s = s ^ ((rate_of(i) == 64) ? {d_data[g][63:0], 256'h0} : {d_data[g], 192'h0});
              default:    s = s ^ ((rate_of(i) == 64) ? {64'h0, d_key[g], 128'h0} : {128'h0, d_key[g], 64'h0});
            endcase
            if (op == 2'd2) m_cipher[i] = (rate_of(i) == 64) ? {64'h0, s[319:256]} : s[319:192];
            s = perm(s, n);
            if (op == 2'd0 || op == 2'd3) s[127:0] = s[127:0] ^ d_key[g];
            if (op == 2'd1 && d_last[g]) s[0] = ~s[0];
            if (op == 2'd3) m_tag[i] = s[127:0];
            m_state[i] = s;
            m_lat[i]   = n / unroll_of(i) + 1;
            m_age[i]   = 1;
          end
        end else if (m_age[i] == m_lat[i]) begin
          m_age[i] = 0;
        end else begin
          m_age[i] = m_age[i] + 1;
        end
      end
    end
  end

  task automatic check(input string name, input int inst, input logic [319:0] act, input logic [319:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] @%0t: got %h want %h", name, inst, $time, act, exp);
    end
  endtask

  // Compare process: handshake every cycle, data outputs whenever idle or done.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      check("ready", i, 320'(o_ready[i]), 320'(m_age[i] == 0));
      check("done", i, 320'(o_done[i]), 320'(m_age[i] != 0 && m_age[i] == m_lat[i]));
      if (m_age[i] == 0 || m_age[i] == m_lat[i]) begin
        check("state", i, o_state[i], m_state[i]);
        check("cipher", i, 320'(o_cipher[i]), 320'(m_cipher[i]));
        check("tag", i, 320'(o_tag[i]), 320'(m_tag[i]));
      end
    end
  end

  function automatic bit group_idle(input int g);
    for (int i = 0; i < NI; i++)
      if (grp_of(i) == g && m_age[i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic wait_idle(input int g);
    int guard = 0;
    while (!group_idle(g)) begin
      @(negedge clk);
      guard++;
      if (guard > 100) begin
        n_cmp++; n_bad++;
        $display("FAIL idle_wait grp=%0d: busy after %0d cycles, want idle", g, guard);
        return;
      end
    end
  endtask

  // One phase; the cycle after accept carries a junk start with scrambled op/data that must be ignored.
  task automatic phase(input int g, input logic [1:0] op, input logic last, input logic [127:0] data);
    wait_idle(g);
    d_start[g] = 1'b1; d_op[g] = op; d_last[g] = last; d_data[g] = data;
    @(negedge clk);
    d_start[g] = 1'($urandom_range(0, 1));
    d_op[g]    = 2'($urandom);
    d_last[g]  = 1'($urandom);
    d_data[g]  = rand128();
    d_state[g] = {rand128(), rand128(), 64'($urandom)};
    @(negedge clk);
    d_start[g] = 1'b0;
  endtask

  task automatic aead(input int g, input logic [127:0] key, input logic [127:0] nonce);
    int nad, npt;
    d_key[g]   = key;
    d_state[g] = {(g == 0) ? IV_128 : IV_128A, key, nonce};
    phase(g, 2'd0, 1'b0, '0);
    nad = $urandom_range(0, 2);
    for (int k = 0; k < nad; k++) phase(g, 2'd1, k == nad - 1, rand128());
    npt = $urandom_range(1, 3);
    for (int k = 0; k < npt - 1; k++) phase(g, 2'd2, 1'b0, rand128());
    phase(g, 2'd2, 1'b1, rand128());
    phase(g, 2'd3, 1'b0, '0);
    wait_idle(g);
  endtask

  localparam logic [127:0] T_KEY   = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] T_NONCE = 128'h00112233445566778899AABBCCDDEEFF;

  initial begin
    int cnt [4];
    int exp_cnt [4];
    exp_cnt = '{13, 7, 5, 3};
    for (int g = 0; g < 2; g++) begin
      d_start[g] = 1'b0; d_op[g] = 2'd0; d_last[g] = 1'b0;
      d_state[g] = '0; d_data[g] = '0; d_key[g] = '0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Hand-derived single final round (index 11) of an all-zero state pins the model.
    check("model_pin", 0, perm(320'h0, 1),
          {64'h000964B00000004B, 64'h0000000096000213, 64'h53FFFFFFFFFFFF90,
           64'h12E580000000004B, 64'h0});

    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // PT last straight out of reset: zero state, rate becomes the data, no rounds.
    phase(0, 2'd2, 1'b1, 128'h436F6E636576657A);
    wait_idle(0);
    for (int i = 0; i < 4; i++) begin
      check("pt_lit_state", i, o_state[i], {64'h436F6E636576657A, 256'h0});
      check("pt_lit_cipher", i, 320'(o_cipher[i]), 320'h436F6E636576657A);
    end

    // Reference INIT with ready-low duration per unroll factor.
    d_key[0]   = T_KEY;
    d_state[0] = {IV_128, T_KEY, T_NONCE};
    d_op[0] = 2'd0; d_last[0] = 1'b0; d_start[0] = 1'b1;
    @(negedge clk);
    d_start[0] = 1'b0;
    cnt = '{0, 0, 0, 0};
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < 4; i++) if (!o_ready[i]) cnt[i]++;
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) check("init_busy_cycles", i, 320'(cnt[i]), 320'(exp_cnt[i]));
    phase(0, 2'd1, 1'b1, 128'h3230323380000000);
    phase(0, 2'd2, 1'b0, 128'h436F6E636576657A);
    phase(0, 2'd2, 1'b1, 128'h0123456789ABCDEF);
    phase(0, 2'd3, 1'b0, '0);
    wait_idle(0);

    // Reset during the fifth cycle of INIT aborts everything.
    d_state[0] = {IV_128, T_KEY, rand128()};
    d_op[0] = 2'd0; d_start[0] = 1'b1;
    @(negedge clk);
    d_start[0] = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    repeat (5) aead(0, rand128(), rand128());
    aead(1, T_KEY, T_NONCE);
    repeat (4) aead(1, rand128(), rand128());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
